// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter and the ALU it shares.
// Opcode encodings double as the ALU's instruction set.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int OPC_W = 4;

    localparam int OVF  = 2;
    localparam int NEG  = 1;
    localparam int ZERO = 0;

    localparam logic [OPC_W-1:0] OP_ADD = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h1;
    localparam logic [OPC_W-1:0] OP_AND = 4'h2;
    localparam logic [OPC_W-1:0] OP_OR  = 4'h3;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h4;
    localparam logic [OPC_W-1:0] OP_SHL = 4'h5;
    localparam logic [OPC_W-1:0] OP_SHR = 4'h6;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between N_REQ requesters and the shared ALU arbiter.
// The master side drives requests and response-ready; the slave is the arbiter.
interface alu_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int BW    = 16,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*BW-1:0] req_a;
    logic [N_REQ*BW-1:0] req_b;
    logic [N_REQ*4-1:0]  req_opcode;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [BW-1:0]       rsp_out;
    logic [2:0]          rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_opcode, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_opcode, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out, rsp_flags
    );
endinterface

// File: rtl/alu.sv
// Combinational BW-bit ALU with {overflow, negative, zero} flags.
// Overflow is meaningful for ADD/SUB only and reads 0 for every other opcode.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic signed [BW-1:0]    a_i,
    input  logic signed [BW-1:0]    b_i,
    input  logic        [OPC_W-1:0] op_i,
    output logic signed [BW-1:0]    result_o,
    output logic        [2:0]       flags_o
);
    logic ovf;

    always_comb begin
        result_o = a_i;
        ovf      = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                result_o = a_i + b_i;
                ovf      = (a_i[BW-1] == b_i[BW-1]) && (result_o[BW-1] != a_i[BW-1]);
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                ovf      = (a_i[BW-1] != b_i[BW-1]) && (result_o[BW-1] != a_i[BW-1]);
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SHL:  result_o = a_i << b_i[3:0];
            OP_SHR:  result_o = a_i >> b_i[3:0];
            default: result_o = a_i;
        endcase
        flags_o       = '0;
        flags_o[OVF]  = ovf;
        flags_o[NEG]  = result_o[BW-1];
        flags_o[ZERO] = (result_o == '0);
    end
endmodule

// File: rtl/alu_arbiter_picker.sv
// rr_picker: combinational round-robin selector returning a one-hot grant.
// Scans upward from ptr_i with wrap; found_o is low when no request is present.
module rr_picker #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             found_o
);
    logic [ID_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr_i) + k) % N_REQ);
            if (!found_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found_o      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters (IDLE->EXEC->RESP).
// Optional per-requester saturating grant counters under `ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int BW    = 16,
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_arbiter_if.slave       bus
`ifdef ALU_ARB_STATS_EN
    , output logic [N_REQ*16-1:0] grant_cnt
`endif
);
    localparam int ID_W = $clog2(N_REQ);

    state_t state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic signed [BW-1:0] a_q, a_d, b_q, b_d;
    logic [OPC_W-1:0]     op_q, op_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic signed [BW-1:0] rsp_out_q, rsp_out_d;
    logic [2:0]           rsp_flags_q, rsp_flags_d;

    logic [N_REQ-1:0]     grant;
    logic                 found;
    logic [ID_W-1:0]      gnt_id;
    logic signed [BW-1:0] alu_out;
    logic [2:0]           alu_flags;
    logic [N_REQ-1:0]     hs;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .found_o (found)
    );

    alu #(.BW(BW)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_out),
        .flags_o  (alu_flags)
    );

    assign bus.req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign hs            = bus.req_valid & bus.req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_flags = rsp_flags_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;
        gnt_id      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gnt_id = ID_W'(i);
            end
        end
        unique case (state_q)
            IDLE: begin
                // Stage 0: capture the granted requester's operands
                if (found) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (grant[i]) begin
                            a_d  = bus.req_a[i*BW +: BW];
                            b_d  = bus.req_b[i*BW +: BW];
                            op_d = bus.req_opcode[i*OPC_W +: OPC_W];
                        end
                    end
                    id_d     = gnt_id;
                    rr_ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Stage 1: register the ALU result
                rsp_out_d   = alu_out;
                rsp_flags_d = alu_flags;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (hs[i] && cnt_q[i] != 16'hFFFF) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

    // A requester must keep its request up until it is accepted.
    for (genvar g = 0; g < N_REQ; g++) begin : g_hold
        req_hold_a: assert property (@(posedge clk) disable iff (rst)
            (bus.req_valid[g] && !bus.req_ready[g]) |=> bus.req_valid[g]);
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a response scoreboard and grant log.
// Define ALU_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.N_REQ(N), .BW(BW)) bus ();

    logic [N-1:0]  vld    = '0;
    logic [N-1:0]  keep   = '0;
    logic          rsp_rdy = 1'b1;
    logic [15:0]   a_v  [N];
    logic [15:0]   b_v  [N];
    logic [3:0]    op_v [N];

`ifdef ALU_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    alu_arbiter #(.BW(BW), .N_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt (grant_cnt)
`endif
    );

    assign bus.req_valid = vld;
    assign bus.rsp_ready = rsp_rdy;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*16 +: 16]     = a_v[i];
            bus.req_b[i*16 +: 16]     = b_v[i];
            bus.req_opcode[i*4 +: 4]  = op_v[i];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [20:0] sb [$];
    int gq [$];
    int gc [$];
    logic rsp_chk = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, neg, zero, result}; overflow from the true integer sum/difference.
    function automatic logic [18:0] model(logic [3:0] op, logic [15:0] a, logic [15:0] b);
        logic [15:0] r;
        int s;
        logic v;
        v = 1'b0;
        s = 0;
        case (op)
            OP_ADD: begin r = a + b; s = int'($signed(a)) + int'($signed(b)); v = (s > 32767) || (s < -32768); end
            OP_SUB: begin r = a - b; s = int'($signed(a)) - int'($signed(b)); v = (s > 32767) || (s < -32768); end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = a;
        endcase
        return {v, r[15], (r == 16'h0), r};
    endfunction

    task automatic tick();
        logic [N-1:0] hs;
        logic cons;
        logic [20:0] e;
        @(negedge clk);
        hs   = rst ? '0 : (vld & bus.req_ready);
        cons = bus.rsp_valid & rsp_rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            sb.delete();
            rsp_chk = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                sb.push_back({2'(i), model(op_v[i], a_v[i], b_v[i])});
                gq.push_back(i);
                gc.push_back(cyc);
                if (!keep[i]) vld[i] = 1'b0;
            end
        end
        if (cons) rsp_chk = 1'b0;
        if (bus.rsp_valid && !rsp_chk) begin
            rsp_chk = 1'b1;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_rsp_id", 32'(bus.rsp_id), 32'(e[20:19]));
                chk("sb_rsp_flags", 32'(bus.rsp_flags), 32'(e[18:16]));
                chk("sb_rsp_out", 32'(bus.rsp_out), 32'(e[15:0]));
            end
        end
    endtask

    task automatic wait_grants(int n);
        int k;
        k = 0;
        while (gq.size() < n && k < 60) begin
            tick();
            k++;
        end
        chk("grant_timeout", 32'(gq.size() >= n), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((vld != 0 || sb.size() != 0 || bus.rsp_valid) && k < 200) begin
            tick();
            k++;
        end
        chk("drain_timeout", 32'(k < 200), 32'd1);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            a_v[i] = 16'(i + 1); b_v[i] = 16'h0; op_v[i] = OP_ADD;
        end

        // Reset with every requester valid
        vld = 4'hF; keep = 4'hF; rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_out", 32'(bus.rsp_out), 32'd0);
            chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        end
        vld = '0; keep = '0;
        tick();
        rst = 1'b0;

        // Single request with signed overflow
        gq.delete(); gc.delete();
        a_v[2] = 16'h7FFF; b_v[2] = 16'h0001; op_v[2] = OP_ADD; vld[2] = 1'b1;
        tick();
        chk("single_grant_cnt", 32'(gq.size()), 32'd1);
        chk("single_lat_edge1", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("single_lat_edge2", 32'(bus.rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(bus.rsp_id), 32'd2);
        chk("single_rsp_out", 32'(bus.rsp_out), 32'h8000);
        chk("single_rsp_flags", 32'(bus.rsp_flags), 32'b110);
        drain();

        // Fairness from a fresh pointer
        reset_pulse();
        gq.delete(); gc.delete();
        for (int i = 0; i < N; i++) begin
            a_v[i] = 16'($urandom); b_v[i] = 16'($urandom);
            op_v[i] = 4'($urandom_range(0, 4));
        end
        keep = 4'hF; vld = 4'hF;
        wait_grants(8);
        for (int k = 0; k < 8; k++) chk("fair_order", 32'(gq[k]), 32'(k % N));
        for (int k = 1; k < 8; k++) chk("fair_spacing", 32'(gc[k] - gc[k-1]), 32'd3);
        keep = '0;
        drain();

        // Backpressure while another requester waits
        gq.delete(); gc.delete();
        a_v[1] = 16'h1234; b_v[1] = 16'h1234; op_v[1] = OP_SUB;
        rsp_rdy = 1'b0; vld[1] = 1'b1;
        tick();
        a_v[3] = 16'hFFFF; b_v[3] = 16'h0000; op_v[3] = OP_XOR; vld[3] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
            chk("bp_rsp_out", 32'(bus.rsp_out), 32'h0000);
            chk("bp_rsp_flags", 32'(bus.rsp_flags), 32'b001);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        chk("bp_no_regrant", 32'(gq.size()), 32'd1);
        rsp_rdy = 1'b1;
        tick();
        chk("bp_release_grants", 32'(gq.size()), 32'd1);
        chk("bp_release_ready", 32'(bus.req_ready), 32'b1000);
        tick();
        chk("bp_next_grant", 32'(gq[gq.size()-1]), 32'd3);
        drain();

        // Wrap, then reset during EXEC
        gq.delete(); gc.delete();
        vld[3] = 1'b1;
        tick();
        chk("wrap_grant", 32'(gq[0]), 32'd3);
        chk("wrap_ptr", 32'(dut.rr_ptr_q), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("exec_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("exec_rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
        vld[0] = 1'b1; vld[3] = 1'b1;
        tick();
        chk("exec_rst_first", 32'(gq[gq.size()-1]), 32'd0);
        drain();

        // Reset during RESP restores the pointer to 0
        gq.delete(); gc.delete();
        rsp_rdy = 1'b0; vld[1] = 1'b1;
        tick();
        tick();
        chk("resp_rst_ptr_before", 32'(dut.rr_ptr_q), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("resp_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("resp_rst_ptr", 32'(dut.rr_ptr_q), 32'd0);
        rsp_rdy = 1'b1; vld[0] = 1'b1; vld[2] = 1'b1;
        tick();
        chk("resp_rst_first", 32'(gq[gq.size()-1]), 32'd0);
        drain();

`ifdef ALU_ARB_STATS_EN
        reset_pulse();
        chk("cnt_clear", 32'(grant_cnt == '0), 32'd1);
        for (int k = 0; k < 5; k++) begin
            vld[1] = 1'b1;
            drain();
        end
        chk("cnt_r1", 32'(grant_cnt[16 +: 16]), 32'd5);
        chk("cnt_r0", 32'(grant_cnt[0 +: 16]), 32'd0);
        chk("cnt_r2", 32'(grant_cnt[32 +: 16]), 32'd0);
        chk("cnt_r3", 32'(grant_cnt[48 +: 16]), 32'd0);
        @(negedge clk);
        force dut.cnt_q = {16'h0, 16'h0, 16'hFFFF, 16'h0};
        @(negedge clk);
        release dut.cnt_q;
        vld[1] = 1'b1;
        drain();
        chk("cnt_saturate", 32'(grant_cnt[16 +: 16]), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance (BW-bit, 4-bit opcode, 3-bit flags {overflow, negative, zero}) between N_REQ independent requesters.
- Round-robin arbitration, valid/ready request handshake per requester, and one shared response channel tagged with the requester id.
- Operands are registered before the ALU and the result is registered after it, so no combinational path runs from requester to result.

Parameters:
- BW, 16: operand/result bitwidth; passed to the `alu` instance.
- N_REQ, 4: number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ): width of the requester id (derived localparam).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set.
- req_a  in  N_REQ*BW  operand A; slice i belongs to requester i.
- req_b  in  N_REQ*BW  operand B, same slicing.
- req_opcode  in  N_REQ*4  ALU opcode, same slicing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_out  out  BW  registered ALU result.
- rsp_flags  out  3  registered ALU flags {overflow, negative, zero}.

Behaviour:
- Reset: rst=1 at a clock edge forces the following, overriding any other event in that cycle:
  - state=IDLE, rr_ptr=0;
  - rsp_valid=0, rsp_id=0, rsp_out=0, rsp_flags=0;
  - operand registers=0.
  - req_ready is 0 during reset.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - Grant is chosen combinationally: the first i with req_valid[i]=1, scanning from rr_ptr upward with wrap at N_REQ-1 to 0.
  - req_ready[grant]=1; all other req_ready bits are 0. No valid request gives req_ready=0.
  - On handshake (req_valid[i] & req_ready[i]): latch a, b, opcode and id; rr_ptr <= (i+1) mod N_REQ; go to EXEC.
- EXEC:
  - The ALU sees the latched operands.
  - rsp_out/rsp_flags/rsp_id <= ALU output and latched id; rsp_valid <= 1; go to RESP.
  - req_ready=0.
- RESP:
  - Hold all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid <= 0 and go to IDLE. There is no same-cycle re-grant, so the next handshake occurs at the earliest in the following cycle.
  - req_ready=0.
- Latency: handshake at edge t gives rsp_valid=1 after edge t+1. Throughput is at most 1 op per 3 cycles with rsp_ready tied high.
- Requester rules:
  - req_valid, once high, must stay high with stable data until accepted.
  - Dropping req_valid before acceptance is a protocol violation and is flagged by an assertion in simulation.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 grants.
- Single requester: the same requester can be granted back-to-back; rr_ptr wraps correctly from N_REQ-1 to 0.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response, and rr_ptr returns to 0.
- Width rules: the result and flags are taken verbatim from the ALU. This block performs no arithmetic beyond rr_ptr modulo N_REQ.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt, width N_REQ*16: one 16-bit saturating counter per requester.
  - A counter increments on each handshake of its requester and holds at 16'hFFFF.
  - Counters clear on rst.
- Undefined: the port and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package alu_arbiter_pkg holds:
  - typedef state_t enum {IDLE, EXEC, RESP};
  - the ALU opcode width constant (4) and flag bit index constants OVF=2, NEG=1, ZERO=0.
- One sub-module, rr_picker (N_REQ): purely combinational. Inputs are req vector and rr_ptr; outputs are one-hot grant plus a found flag. This sub-module is reused by later arbiters.
- The `alu` is instantiated unchanged inside alu_arbiter.

Test Plan:
- Reset: assert rst for 2 cycles with req_valid=4'hF -> req_ready=0, rsp_valid=0, rsp_out=0, rsp_flags=0.
- Single request: requester 2 sends a=16'h7FFF, b=16'h0001, ADD -> rsp_valid exactly 2 edges after the handshake, rsp_id=2, rsp_out=16'h8000, rsp_flags=3'b110.
- Fairness: req_valid=4'hF held with rsp_ready=1, 8 ops -> grant order 0,1,2,3,0,1,2,3; rsp_id sequence matches; each op takes 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout; the pending requester is granted only after the rsp_ready=1 cycle.
- Wrap and mid-operation reset: only requester 3 valid, granted, then rst pulsed during EXEC -> no rsp_valid, rr_ptr=0. Next, requester 0 and 3 valid -> requester 0 granted first.
- With ALU_ARB_STATS_EN: 5 grants to requester 1 -> grant_cnt slice 1 = 5, other slices 0. Force a counter to 16'hFFFF and grant again -> it stays 16'hFFFF.
